uart_transceiver: RTL and testbench
===================================

// Module: uart_transceiver
// PURPOSE
//   Parametrised full-duplex UART: frame transmitter plus oversampling receiver on one clock.
//   Configurable data width, parity mode, stop-bit count, bit period and synchroniser depth.
//   Adds framing-error detection and false-start rejection.
//   Sits between the host-side byte interface and the pad-level serial lines.
// PARAMETERS
//   INPUT_DATA_WIDTH            8  data bits per frame, 5..9
//   PARITY_ENABLED              1  1 = parity bit present, 0 = none
//   PARITY_TYPE                 0  0 = even, 1 = odd (ignored if PARITY_ENABLED=0)
//   STOP_BITS                   1  stop bits transmitted, 1 or 2
//   CLOCKS_PER_BIT              8  clk cycles per bit, even, >=4
//   NUMBER_OF_RX_SYNCHRONIZERS  3  FF stages on serial_in, >=2
// PORTS
//   clk            in   1    system clock
//   reset          in   1    synchronous, active-high
//   enable         in   1    Tx start request, sampled when o_busy=0
//   i_data         in   W    Tx payload, W=INPUT_DATA_WIDTH
//   o_busy         out  1    Tx frame in progress
//   serial_out     out  1    Tx line, idle high
//   serial_in      in   1    Rx line, asynchronous
//   received_data  out  W    last received payload
//   data_is_valid  out  1    1-cycle pulse: received_data updated
//   rx_error       out  1    parity mismatch, qualified by data_is_valid
//   framing_error  out  1    stop bit sampled low, qualified by data_is_valid
// BEHAVIOUR
//   Reset: serial_out=1, o_busy=0, data_is_valid=0, rx_error=0, framing_error=0,
//     received_data=0, synchroniser flops=1, both FSMs IDLE. Mid-frame reset aborts at once.
//   Frame: start(0), data LSB first, parity (even: ^data; odd: ~^data), STOP_BITS x 1.
//     Every bit held exactly CLOCKS_PER_BIT cycles.
//   Tx FSM: IDLE->START->DATA->PARITY(if enabled)->STOP->IDLE.
//   Tx accept: cycle A with enable=1 and o_busy=0 latches i_data.
//     o_busy=1 and serial_out=0 from A+1.
//   enable while o_busy=1 is ignored. i_data is don't-care after accept.
//   o_busy falls after the last stop-bit cycle.
//     enable in that same cycle is accepted; the next start bit follows with no idle gap.
//   Rx FSM: IDLE->START->DATA->PARITY(if enabled)->STOP->IDLE. Bit counter and cycle counter are modulo.
//   Detect cycle D: first cycle the synchroniser output is 0 while Rx is IDLE.
//   Bit k (k=0 is start) is sampled at D + k*CPB + CPB/2.
//   Start sample = 1: false start, return to IDLE, no output pulse.
//   Only the first stop bit is sampled; Rx returns to IDLE right after it (resyncs on next edge).
//   Cycle after stop sample:
//     received_data <= shifted data; data_is_valid=1 for one cycle;
//     rx_error = parity mismatch (0 if parity disabled); framing_error = !stop sample.
//     data_is_valid fires even when either error flag is set.
//   Both error flags are 0 whenever data_is_valid=0.
//   Loopback latency: data_is_valid at A + 2 + S + (1+W+P)*CPB + CPB/2.
//     S = NUMBER_OF_RX_SYNCHRONIZERS, P = PARITY_ENABLED. Defaults: A+89.
//   Tx and Rx are fully independent; a simultaneous Tx accept and Rx detect need no arbitration.
// CONFIGURATION
//   UART_LOOPBACK_EN defined: Rx synchroniser input = serial_out internally; serial_in ignored.
//   UART_LOOPBACK_EN undefined: Rx synchroniser input = serial_in.
// TESTING
//   1 Loopback, defaults, i_data=8'hA5 at A -> data_is_valid at A+89,
//     received_data=8'hA5, rx_error=0, framing_error=0.
//   2 PARITY_TYPE=1, i_data=8'h00 -> serial_out parity bit=1.
//     Rx with even-parity frame injected on serial_in -> rx_error=1 with data_is_valid.
//   3 serial_in: start, 8'h3C, parity, stop forced 0
//     -> data_is_valid=1, received_data=8'h3C, framing_error=1.
//   4 serial_in low pulse of 3 cycles (< CPB/2), then high
//     -> Rx back to IDLE, no data_is_valid; a following valid frame is received correctly.
//   5 STOP_BITS=2, enable held high, i_data 8'h11 then 8'h22
//     -> o_busy=1 for 12*CPB cycles per frame, start bits back-to-back;
//        enable mid-frame ignored; loopback yields 8'h11 then 8'h22.
//   6 Reset in the middle of a data bit -> next cycle serial_out=1, o_busy=0;
//     no data_is_valid; next accepted frame completes normally.

Source files
------------

// File: rtl/uart_transceiver.sv
// uart_transceiver
//   Full-duplex UART on a single clock: a frame transmitter and an
//   oversampling receiver with framing-error detection and false-start
//   rejection. It sits between a host-side word interface and the pad-level
//   serial lines.
//
//   Frame format: start(0), data LSB first, optional parity, STOP_BITS x 1.
//   Every bit is held for CLOCKS_PER_BIT clock cycles.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high
//   enable         in   Tx start request, sampled when the transmitter is free
//   i_data         in   Tx payload (INPUT_DATA_WIDTH bits)
//   o_busy         out  Tx frame in progress
//   serial_out     out  Tx line, idle high
//   serial_in      in   Rx line, asynchronous
//   received_data  out  last received payload
//   data_is_valid  out  1-cycle pulse, received_data updated
//   rx_error       out  parity mismatch, qualified by data_is_valid
//   framing_error  out  stop bit sampled low, qualified by data_is_valid
//
// Build option
//   UART_LOOPBACK_EN  when defined, the Rx synchroniser is fed from serial_out
//                     internally and serial_in is ignored.
module uart_transceiver #(
  parameter int INPUT_DATA_WIDTH           = 8,
  parameter int PARITY_ENABLED             = 1,
  parameter int PARITY_TYPE                = 0,
  parameter int STOP_BITS                  = 1,
  parameter int CLOCKS_PER_BIT             = 8,
  parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [INPUT_DATA_WIDTH-1:0] i_data,
  output logic                        o_busy,
  output logic                        serial_out,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        data_is_valid,
  output logic                        rx_error,
  output logic                        framing_error
);

  localparam int W  = INPUT_DATA_WIDTH;
  localparam int S  = NUMBER_OF_RX_SYNCHRONIZERS;
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int BW = $clog2(W);

  localparam logic [CW-1:0] LAST_CYC  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CYC  = CW'(CLOCKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_DATA = BW'(W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // ---------------------------------------------------------------- Tx
  logic [2:0]    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [BW-1:0] r_tx_bit;
  logic [W-1:0]  r_tx_data;
  logic          r_tx_par;
  logic          r_serial_out;
  logic          r_busy;
  logic          w_tx_bit_end;
  logic          w_tx_accept;
  logic          w_tx_par;

  // A request in the last stop-bit cycle is taken immediately so that
  // back-to-back frames have no idle gap between stop and start bits.
  always_comb begin
    w_tx_bit_end = (r_tx_cnt == LAST_CYC);
    w_tx_accept  = enable && ((r_tx_state == ST_IDLE) ||
                   ((r_tx_state == ST_STOP) && w_tx_bit_end && (r_tx_bit == LAST_STOP)));
    w_tx_par     = (PARITY_TYPE != 0) ? ~^i_data : ^i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state   <= ST_IDLE;
      r_tx_cnt     <= '0;
      r_tx_bit     <= '0;
      r_tx_data    <= '0;
      r_tx_par     <= 1'b0;
      r_serial_out <= 1'b1;
      r_busy       <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_state   <= ST_START;
      r_tx_cnt     <= '0;
      r_tx_bit     <= '0;
      r_tx_data    <= i_data;
      r_tx_par     <= w_tx_par;
      r_serial_out <= 1'b0;
      r_busy       <= 1'b1;
    end else if (r_tx_state != ST_IDLE) begin
      if (!w_tx_bit_end) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end else begin
        r_tx_cnt <= '0;
        case (r_tx_state)
          ST_START: begin
            r_tx_state   <= ST_DATA;
            r_tx_bit     <= '0;
            r_serial_out <= r_tx_data[0];
          end
          ST_DATA: begin
            if (r_tx_bit == LAST_DATA) begin
              r_tx_bit <= '0;
              if (PARITY_ENABLED != 0) begin
                r_tx_state   <= ST_PARITY;
                r_serial_out <= r_tx_par;
              end else begin
                r_tx_state   <= ST_STOP;
                r_serial_out <= 1'b1;
              end
            end else begin
              // Payload shifts right so the next bit is always at index 1.
              r_tx_bit     <= r_tx_bit + 1'b1;
              r_serial_out <= r_tx_data[1];
              r_tx_data    <= {1'b0, r_tx_data[W-1:1]};
            end
          end
          ST_PARITY: begin
            r_tx_state   <= ST_STOP;
            r_tx_bit     <= '0;
            r_serial_out <= 1'b1;
          end
          ST_STOP: begin
            if (r_tx_bit == LAST_STOP) begin
              r_tx_state   <= ST_IDLE;
              r_busy       <= 1'b0;
              r_serial_out <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
            end
          end
          default: begin
            r_tx_state   <= ST_IDLE;
            r_busy       <= 1'b0;
            r_serial_out <= 1'b1;
          end
        endcase
      end
    end
  end

  assign serial_out = r_serial_out;
  assign o_busy     = r_busy;

  // ---------------------------------------------------------------- Rx
  logic          w_rx_in;
`ifdef UART_LOOPBACK_EN
  assign w_rx_in = r_serial_out;
`else
  assign w_rx_in = serial_in;
`endif

  logic [S-1:0]  r_sync;
  logic [2:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [BW-1:0] r_rx_bit;
  logic [W-1:0]  r_rx_shift;
  logic          r_rx_par;
  logic [W-1:0]  r_rx_data;
  logic          r_rx_valid;
  logic          r_rx_perr;
  logic          r_rx_ferr;
  logic          w_rx_bit;
  logic          w_rx_par_err;

  always_comb begin
    w_rx_bit     = r_sync[S-1];
    w_rx_par_err = (PARITY_ENABLED != 0) &&
                   (r_rx_par != ((PARITY_TYPE != 0) ? ~^r_rx_shift : ^r_rx_shift));
  end

  // The cycle counter runs modulo CLOCKS_PER_BIT from the detect cycle (count
  // 0), so every bit is sampled at its centre when the count hits half.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '1;
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[S-2:0], w_rx_in};
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (r_rx_state == ST_IDLE) begin
        if (!w_rx_bit) begin
          r_rx_state <= ST_START;
          r_rx_cnt   <= CW'(1);
        end
      end else begin
        r_rx_cnt <= (r_rx_cnt == LAST_CYC) ? '0 : r_rx_cnt + 1'b1;
        if (r_rx_cnt == HALF_CYC) begin
          case (r_rx_state)
            ST_START: begin
              r_rx_state <= w_rx_bit ? ST_IDLE : ST_DATA;
              r_rx_bit   <= '0;
            end
            ST_DATA: begin
              r_rx_shift <= {w_rx_bit, r_rx_shift[W-1:1]};
              if (r_rx_bit == LAST_DATA) begin
                r_rx_bit   <= '0;
                r_rx_state <= (PARITY_ENABLED != 0) ? ST_PARITY : ST_STOP;
              end else begin
                r_rx_bit <= r_rx_bit + 1'b1;
              end
            end
            ST_PARITY: begin
              r_rx_par   <= w_rx_bit;
              r_rx_state <= ST_STOP;
            end
            ST_STOP: begin
              r_rx_state <= ST_IDLE;
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              r_rx_perr  <= w_rx_par_err;
              r_rx_ferr  <= !w_rx_bit;
            end
            default: r_rx_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign received_data = r_rx_data;
  assign data_is_valid = r_rx_valid;
  assign rx_error      = r_rx_perr;
  assign framing_error = r_rx_ferr;

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: dut0 uses default parameters, dut1 uses odd
// parity and two stop bits. Expected receive events go into per-DUT queues;
// a monitor pops and compares them whenever data_is_valid pulses.
module tb_uart_transceiver;

  localparam int CPB     = 8;
  localparam int LAT_TX  = 89;  // accept cycle -> data_is_valid (loopback)
  localparam int LAT_INJ = 88;  // first start-bit cycle on serial_in -> data_is_valid

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       inj0 = 1'b1, inj1 = 1'b1;
  logic       lb0 = 1'b0, lb1 = 1'b0;

  logic       busy0, so0, si0, dv0, re0, fe0;
  logic       busy1, so1, si1, dv1, re1, fe1;
  logic [7:0] rd0, rd1;

  assign si0 = lb0 ? so0 : inj0;
  assign si1 = lb1 ? so1 : inj1;

  uart_transceiver dut0 (
    .clk(clk), .reset(rst), .enable(en0), .i_data(d0), .o_busy(busy0),
    .serial_out(so0), .serial_in(si0), .received_data(rd0),
    .data_is_valid(dv0), .rx_error(re0), .framing_error(fe0)
  );

  uart_transceiver #(.PARITY_TYPE(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst), .enable(en1), .i_data(d1), .o_busy(busy1),
    .serial_out(so1), .serial_in(si1), .received_data(rd1),
    .data_is_valid(dv1), .rx_error(re1), .framing_error(fe1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int nv0 = 0, nv1 = 0;

  typedef struct {
    logic [7:0] d;
    logic       re;
    logic       fe;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  function automatic void check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (dv0) begin
        nv0++;
        if (q0.size() == 0) check("dut0_unexpected_valid", 1, 0);
        else begin
          m0 = q0.pop_front();
          check("dut0_data", int'(rd0), int'(m0.d));
          check("dut0_rx_error", int'(re0), int'(m0.re));
          check("dut0_framing_error", int'(fe0), int'(m0.fe));
          check("dut0_valid_cycle", cyc, m0.cyc);
        end
      end else if (re0 || fe0) check("dut0_unqualified_error", int'({re0, fe0}), 0);
      if (dv1) begin
        nv1++;
        if (q1.size() == 0) check("dut1_unexpected_valid", 1, 0);
        else begin
          m1 = q1.pop_front();
          check("dut1_data", int'(rd1), int'(m1.d));
          check("dut1_rx_error", int'(re1), int'(m1.re));
          check("dut1_framing_error", int'(fe1), int'(m1.fe));
          check("dut1_valid_cycle", cyc, m1.cyc);
        end
      end else if (re1 || fe1) check("dut1_unqualified_error", int'({re1, fe1}), 0);
    end
  end

  function automatic exp_t mk(input logic [7:0] d, input logic re, input logic fe, input int c);
    exp_t e;
    e.d = d; e.re = re; e.fe = fe; e.cyc = c;
    return e;
  endfunction

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic tx_start(input int sel, input logic [7:0] d, output int a);
    @(posedge clk); #1;
    if (sel == 0) begin d0 = d; en0 = 1'b1; end
    else          begin d1 = d; en1 = 1'b1; end
    a = cyc;
    @(posedge clk); #1;
    en0 = 1'b0;
    en1 = 1'b0;
  endtask

  task automatic inject(input int sel, input logic [7:0] d, input logic par, input logic stp,
                        input logic [7:0] ed, input logic ere, input logic efe);
    logic [10:0] fr;
    int l;
    fr = {stp, par, d, 1'b0};
    @(posedge clk); #1;
    l = cyc;
    if (sel == 0) q0.push_back(mk(ed, ere, efe, l + LAT_INJ));
    else          q1.push_back(mk(ed, ere, efe, l + LAT_INJ));
    for (int i = 0; i < 11; i++) begin
      if (sel == 0) inj0 = fr[i]; else inj1 = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    inj0 = 1'b1;
    inj1 = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    check("drain_dut0", q0.size(), 0);
    check("drain_dut1", q1.size(), 0);
    repeat (20) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int a;
    int snap;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_serial_out0", int'(so0), 1);
    check("rst_busy0", int'(busy0), 0);
    check("rst_valid0", int'(dv0), 0);
    check("rst_rxdata0", int'(rd0), 0);
    check("rst_errors0", int'({re0, fe0}), 0);
    check("rst_serial_out1", int'(so1), 1);
    check("rst_busy1", int'(busy1), 0);
    check("rst_valid1", int'(dv1), 0);

    // Loopback of 8'hA5 with default parameters
    lb0 = 1'b1;
    tx_start(0, 8'hA5, a);
    q0.push_back(mk(8'hA5, 1'b0, 1'b0, a + LAT_TX));
    wait_cyc(a + 1);
    check("t1_start_bit", int'(so0), 0);
    check("t1_busy", int'(busy0), 1);
    drain();
    lb0 = 1'b0;

    // Stop bit forced low: 8'h3C, even parity 0
    inject(0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    drain();

    // Short glitch rejected, then a good frame
    snap = nv0;
    @(posedge clk); #1 inj0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 inj0 = 1'b1;
    repeat (40) @(posedge clk);
    check("t4_no_valid_after_glitch", nv0, snap);
    inject(0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    drain();

    // Reset in the middle of a data bit
    lb0 = 1'b1;
    tx_start(0, 8'hFF, a);
    wait_cyc(a + 30);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_serial_out", int'(so0), 1);
    check("t6_busy", int'(busy0), 0);
    check("t6_rxdata_cleared", int'(rd0), 0);
    snap = nv0;
    repeat (150) @(posedge clk);
    check("t6_no_valid", nv0, snap);
    tx_start(0, 8'hC3, a);
    q0.push_back(mk(8'hC3, 1'b0, 1'b0, a + LAT_TX));
    drain();
    lb0 = 1'b0;

    // Odd parity: transmitted parity bit for 8'h00 is 1
    lb1 = 1'b1;
    tx_start(1, 8'h00, a);
    q1.push_back(mk(8'h00, 1'b0, 1'b0, a + LAT_TX));
    wait_cyc(a + 1 + 9 * CPB + CPB / 2);
    check("t2_odd_parity_bit", int'(so1), 1);
    drain();
    lb1 = 1'b0;
    // Even-parity frame into odd-parity receiver
    inject(1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    drain();

    // Two stop bits, enable held: back-to-back frames 8'h11, 8'h22
    lb1 = 1'b1;
    @(posedge clk); #1;
    d1 = 8'h11; en1 = 1'b1; a = cyc;
    q1.push_back(mk(8'h11, 1'b0, 1'b0, a + LAT_TX));
    q1.push_back(mk(8'h22, 1'b0, 1'b0, a + 12 * CPB + LAT_TX));
    @(posedge clk); #1 d1 = 8'h22;
    wait_cyc(a + 48);
    check("t5_busy_mid", int'(busy1), 1);
    wait_cyc(a + 12 * CPB);
    check("t5_busy_last_stop", int'(busy1), 1);
    check("t5_last_stop_level", int'(so1), 1);
    wait_cyc(a + 12 * CPB + 1);
    check("t5_back_to_back_start", int'(so1), 0);
    check("t5_busy_second", int'(busy1), 1);
    @(posedge clk); #1 en1 = 1'b0;
    wait_cyc(a + 24 * CPB);
    check("t5_busy_end_frame2", int'(busy1), 1);
    wait_cyc(a + 24 * CPB + 1);
    check("t5_busy_falls", int'(busy1), 0);
    check("t5_idle_line", int'(so1), 1);
    drain();
    lb1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
